// File: rtl/fft_bf_sched_if.sv
// Frame-controller handshake plus RAM/ROM address bus of the FFT butterfly sequencer.
// The master drives start/abort, and the sequencer (slave) drives everything else.
interface fft_bf_sched_if #(
  parameter int LOG2N = 6
);
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [3:0]       stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    output start, abort,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, abort,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bf_sched.sv
// Radix-2 DIT in-place FFT sequencer: issues one butterfly per clock and generates
// read, twiddle and delayed write-back addresses. Every output is registered.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | issuing butterfly k of the current stage
// DRAIN   | WR_DLY idle cycles so the stage's writes land before the next stage reads
// DONE    | one-cycle done pulse, then back to IDLE
module fft_bf_sched #(
  parameter int LOG2N   = 6,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_bf_sched_if.slave  bus
);
  localparam int WR_DLY = MEM_LAT + BF_LAT;
  localparam int N      = 1 << LOG2N;
  localparam int AW     = LOG2N;
  localparam int KW     = LOG2N - 1;
  localparam int TW     = LOG2N - 1;
  localparam int CW     = $clog2(WR_DLY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flush;

  logic            busy_q, done_q, rd_en_q;
  logic [AW-1:0]   rd_a_q, rd_b_q;
  logic [TW-1:0]   tw_q;

  logic [AW-1:0]   kx, half, mask, addr_a_d, addr_b_d;
  logic [TW-1:0]   tw_d;

  logic            dl_en_q [WR_DLY];
  logic [AW-1:0]   dl_a_q  [WR_DLY];
  logic [AW-1:0]   dl_b_q  [WR_DLY];

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          stage_d = 4'd0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == KW'(N/2 - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(WR_DLY - 1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          if (stage_q == 4'(LOG2N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 4'd1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = 4'd0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && state_q != S_IDLE) begin
      flush   = 1'b1;
      state_d = S_IDLE;
      stage_d = 4'd0;
      k_d     = '0;
      cnt_d   = '0;
    end
  end

  // Addresses follow the next-state counters so the registered outputs line up with state_q.
  always_comb begin
    kx       = AW'(k_d);
    half     = AW'(1) << stage_d;
    mask     = half - AW'(1);
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    if (state_d == S_RUN) begin
      addr_a_d = ((kx >> stage_d) << (stage_d + 4'd1)) | (kx & mask);
      addr_b_d = addr_a_d | half;
      tw_d     = TW'((kx & mask) << (4'(TW) - stage_d));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= 4'd0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      for (int i = 0; i < WR_DLY; i++) begin
        dl_en_q[i] <= 1'b0;
        dl_a_q[i]  <= '0;
        dl_b_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      rd_en_q <= (state_d == S_RUN);
      rd_a_q  <= addr_a_d;
      rd_b_q  <= addr_b_d;
      tw_q    <= tw_d;
      if (flush) begin
        for (int i = 0; i < WR_DLY; i++) begin
          dl_en_q[i] <= 1'b0;
          dl_a_q[i]  <= '0;
          dl_b_q[i]  <= '0;
        end
      end else begin
        dl_en_q[0] <= rd_en_q;
        dl_a_q[0]  <= rd_a_q;
        dl_b_q[0]  <= rd_b_q;
        for (int i = 1; i < WR_DLY; i++) begin
          dl_en_q[i] <= dl_en_q[i-1];
          dl_a_q[i]  <= dl_a_q[i-1];
          dl_b_q[i]  <= dl_b_q[i-1];
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a_q;
  assign bus.rd_addr_b = rd_b_q;
  assign bus.tw_addr   = tw_q;
  assign bus.wr_en     = dl_en_q[WR_DLY-1];
  assign bus.wr_addr_a = dl_a_q[WR_DLY-1];
  assign bus.wr_addr_b = dl_b_q[WR_DLY-1];
endmodule

// File: tb/tb_fft_bf_sched.sv
// Directed bench for fft_bf_sched: an N=8 instance for sequence/handshake scenarios
// and an N=64 instance for frame length and last-stage addressing.
module tb_fft_bf_sched;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fft_bf_sched_if #(.LOG2N(3)) b3 ();
  fft_bf_sched_if #(.LOG2N(6)) b6 ();

  fft_bf_sched #(.LOG2N(3), .MEM_LAT(1), .BF_LAT(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  fft_bf_sched #(.LOG2N(6), .MEM_LAT(1), .BF_LAT(4)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived butterfly pairs and twiddles for N=8, stages 0..2.
  int ea [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int eb [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int et [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b3.start = 1'b0; b3.abort = 1'b0;
    b6.start = 1'b0; b6.abort = 1'b0;
    #22;
    n_vec++;
    if ({b3.busy, b3.done, b3.stage, b3.rd_en, b3.rd_addr_a, b3.rd_addr_b, b3.tw_addr,
         b3.wr_en, b3.wr_addr_a, b3.wr_addr_b} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b done=%b stage=%0d rd_en=%b wr_en=%b exp all zero",
               b3.busy, b3.done, b3.stage, b3.rd_en, b3.wr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({b3.busy, b3.done, b3.rd_en, b3.wr_en, b6.busy, b6.rd_en} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_idle got %b exp 000000",
               {b3.busy, b3.done, b3.rd_en, b3.wr_en, b6.busy, b6.rd_en});
    end
  endtask

  // Full N=8 frame; optionally pulses start again at cycle pulse_cyc of the frame.
  task automatic frame3(input string name, input int pulse_cyc);
    int s, ph, idx;
    logic exp_rd, exp_wr;
    b3.start = 1'b1;
    tick();
    b3.start = 1'b0;
    for (int c = 0; c < 27; c++) begin
      s      = c / 9;
      ph     = c % 9;
      exp_rd = (ph < 4);
      exp_wr = (ph >= 5);
      idx    = exp_rd ? s*4 + ph : (exp_wr ? s*4 + ph - 5 : 0);
      n_vec++;
      if ({b3.busy, b3.done, b3.stage, b3.rd_en, b3.wr_en} !== {1'b1, 1'b0, 4'(s), exp_rd, exp_wr}) begin
        n_err++;
        $display("FAIL %s ctl c=%0d got %b exp %b", name, c,
                 {b3.busy, b3.done, b3.stage, b3.rd_en, b3.wr_en},
                 {1'b1, 1'b0, 4'(s), exp_rd, exp_wr});
      end
      if (exp_rd) begin
        n_vec++;
        if ({b3.rd_addr_a, b3.rd_addr_b, b3.tw_addr} !== {3'(ea[idx]), 3'(eb[idx]), 2'(et[idx])}) begin
          n_err++;
          $display("FAIL %s rd c=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d", name, c,
                   b3.rd_addr_a, b3.rd_addr_b, b3.tw_addr, ea[idx], eb[idx], et[idx]);
        end
      end
      if (exp_wr) begin
        n_vec++;
        if ({b3.wr_addr_a, b3.wr_addr_b} !== {3'(ea[idx]), 3'(eb[idx])}) begin
          n_err++;
          $display("FAIL %s wr c=%0d got a=%0d b=%0d exp a=%0d b=%0d", name, c,
                   b3.wr_addr_a, b3.wr_addr_b, ea[idx], eb[idx]);
        end
      end
      b3.start = (c == pulse_cyc);
      tick();
    end
    b3.start = 1'b0;
    n_vec++;
    if ({b3.busy, b3.done, b3.rd_en, b3.wr_en} !== 4'b0100) begin
      n_err++;
      $display("FAIL %s done_cycle got %b exp 0100", name, {b3.busy, b3.done, b3.rd_en, b3.wr_en});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if ({b3.busy, b3.done, b3.rd_en, b3.wr_en} !== 4'b0000) begin
        n_err++;
        $display("FAIL %s after_done c=%0d got %b exp 0000", name, c,
                 {b3.busy, b3.done, b3.rd_en, b3.wr_en});
      end
    end
  endtask

  task automatic test_frame();
    frame3("frame", -1);
  endtask

  task automatic test_start_while_busy();
    frame3("start_busy", 10);
  endtask

  task automatic test_abort();
    b3.start = 1'b1;
    tick();
    b3.start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    b3.abort = 1'b1;
    tick();
    b3.abort = 1'b0;
    n_vec++;
    if ({b3.busy, b3.done, b3.rd_en, b3.wr_en, b3.stage} !== 8'd0) begin
      n_err++;
      $display("FAIL abort_next got busy=%b done=%b rd_en=%b wr_en=%b stage=%0d exp all zero",
               b3.busy, b3.done, b3.rd_en, b3.wr_en, b3.stage);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      n_vec++;
      if ({b3.busy, b3.done, b3.rd_en, b3.wr_en} !== 4'b0000) begin
        n_err++;
        $display("FAIL abort_quiet c=%0d got %b exp 0000", c, {b3.busy, b3.done, b3.rd_en, b3.wr_en});
      end
    end
    frame3("after_abort", -1);
  endtask

  task automatic test_back_to_back();
    b3.start = 1'b1;
    tick();
    for (int c = 0; c < 27; c++) tick();
    n_vec++;
    if ({b3.busy, b3.done} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_done got %b exp 01", {b3.busy, b3.done});
    end
    tick();
    n_vec++;
    if ({b3.busy, b3.done, b3.rd_en} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b_idle got %b exp 000", {b3.busy, b3.done, b3.rd_en});
    end
    tick();
    b3.start = 1'b0;
    n_vec++;
    if ({b3.busy, b3.rd_en, b3.stage, b3.rd_addr_a, b3.rd_addr_b} !== {1'b1, 1'b1, 4'd0, 3'd0, 3'd1}) begin
      n_err++;
      $display("FAIL b2b_restart got %b exp %b", {b3.busy, b3.rd_en, b3.stage, b3.rd_addr_a, b3.rd_addr_b},
               {1'b1, 1'b1, 4'd0, 3'd0, 3'd1});
    end
    b3.abort = 1'b1;
    tick();
    b3.abort = 1'b0;
    n_vec++;
    if (b3.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_abort busy got %b exp 0", b3.busy);
    end
  endtask

  task automatic test_reset_mid();
    b3.start = 1'b1;
    tick();
    b3.start = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({b3.busy, b3.done, b3.stage, b3.rd_en, b3.rd_addr_a, b3.rd_addr_b, b3.tw_addr,
         b3.wr_en, b3.wr_addr_a, b3.wr_addr_b} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_mid_async got busy=%b stage=%0d rd_en=%b wr_en=%b exp all zero",
               b3.busy, b3.stage, b3.rd_en, b3.wr_en);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_vec++;
      if ({b3.busy, b3.done, b3.rd_en, b3.wr_en, b3.stage} !== 8'd0) begin
        n_err++;
        $display("FAIL reset_mid_idle c=%0d got busy=%b done=%b rd_en=%b wr_en=%b stage=%0d exp all zero",
                 c, b3.busy, b3.done, b3.rd_en, b3.wr_en, b3.stage);
      end
    end
  endtask

  task automatic test_log2n6();
    int   nb;
    logic seen, got_done;
    logic [5:0] fa, fb, la, lb;
    logic [4:0] ft, lt;
    nb = 0; seen = 1'b0; got_done = 1'b0;
    fa = '0; fb = '0; la = '0; lb = '0; ft = '0; lt = '0;
    b6.start = 1'b1;
    tick();
    b6.start = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (b6.done) begin
        got_done = 1'b1;
      end else begin
        if (b6.busy) nb++;
        if (b6.rd_en && b6.stage == 4'd5) begin
          if (!seen) begin
            fa = b6.rd_addr_a; fb = b6.rd_addr_b; ft = b6.tw_addr; seen = 1'b1;
          end
          la = b6.rd_addr_a; lb = b6.rd_addr_b; lt = b6.tw_addr;
        end
        tick();
      end
    end
    n_vec++;
    if (got_done !== 1'b1) begin
      n_err++;
      $display("FAIL n64_done_timeout got no done in 400 cycles exp done");
    end
    n_vec++;
    if (nb != 222) begin
      n_err++;
      $display("FAIL n64_busy_cycles got %0d exp 222", nb);
    end
    n_vec++;
    if ({seen, fa, fb, ft} !== {1'b1, 6'd0, 6'd32, 5'd0}) begin
      n_err++;
      $display("FAIL n64_first_s5 got seen=%b a=%0d b=%0d tw=%0d exp a=0 b=32 tw=0", seen, fa, fb, ft);
    end
    n_vec++;
    if ({la, lb, lt} !== {6'd31, 6'd63, 5'd31}) begin
      n_err++;
      $display("FAIL n64_last_s5 got a=%0d b=%0d tw=%0d exp a=31 b=63 tw=31", la, lb, lt);
    end
    n_vec++;
    if (b6.busy !== 1'b0) begin
      n_err++;
      $display("FAIL n64_busy_at_done got %b exp 0", b6.busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_frame();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_log2n6();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft_bf_sched.md
Name: fft_bf_sched

Overview:
- Sequencer for an in-place radix-2 DIT FFT built around one shared, fully pipelined butterfly unit: one butterfly issued per clock.
- Generates dual-port data-RAM read addresses, twiddle-ROM address, and delayed write-back addresses/enables for every butterfly of every stage.
- Provides a start/busy/done handshake to the frame-level controller. Input data is already stored in bit-reversed order.
- Contains no datapath: samples and twiddles flow RAM/ROM -> butterfly -> RAM outside this block.

Parameters:
- LOG2N, 6, log2 of FFT length N (N = 2**LOG2N, range 2..10).
- MEM_LAT, 1, cycles from rd_en/address to data at butterfly inputs (sync RAM/ROM).
- BF_LAT, 4, butterfly input-to-output latency in clocks.
- WR_DLY, MEM_LAT+BF_LAT (derived, localparam), cycles from issue to write-back.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request one FFT frame; sampled only in IDLE.
- abort, input, 1, synchronous cancel; takes effect from any non-IDLE state.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when the last write-back of the last stage has been issued.
- stage, output, 4, current stage index 0..LOG2N-1.
- rd_en, output, 1, butterfly issue strobe (RAM read of both operands).
- rd_addr_a, output, LOG2N, address of operand A.
- rd_addr_b, output, LOG2N, address of operand B.
- tw_addr, output, LOG2N-1, twiddle ROM index.
- wr_en, output, 1, write-back strobe for butterfly results X/Y.
- wr_addr_a, output, LOG2N, X destination (= rd_addr_a delayed WR_DLY).
- wr_addr_b, output, LOG2N, Y destination (= rd_addr_b delayed WR_DLY).

Behaviour:
- All outputs are registered. Reset (async assert, sync deassert by user) forces: state=IDLE; every output 0; all WR_DLY delay-line stages cleared, so no write follows reset.
- FSM states:
  - IDLE: start=1 -> RUN, stage=0, k=0.
  - RUN: rd_en=1 every cycle; k increments 0..N/2-1; at k=N/2-1 -> DRAIN.
  - DRAIN: rd_en=0 for exactly WR_DLY cycles, so all writes of the stage land before the next stage reads (RAW safety). Then -> RUN with stage+1, k=0; if stage=LOG2N-1 -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Addressing, with stage s, half=2**s, j=k>>s, p=k&(half-1):
  - rd_addr_a = (j<<(s+1)) | p.
  - rd_addr_b = rd_addr_a + half (no carry; always < N).
  - tw_addr = p << (LOG2N-1-s), truncated to LOG2N-1 bits.
- Write path: wr_en/wr_addr_a/wr_addr_b are exactly rd_en/rd_addr_a/rd_addr_b delayed WR_DLY cycles through a shift register. The last wr_en of a stage occurs in the final DRAIN cycle.
- busy rises the cycle after start is sampled.
- Total frame time: busy high for LOG2N*(N/2+WR_DLY) cycles, then the DONE cycle.
- start while busy: ignored, not queued. start in the DONE cycle: ignored. start held high continuously: a new frame begins the cycle after DONE (IDLE samples it).
- abort: next cycle state=IDLE; busy, rd_en, stage and k cleared; delay line flushed (wr_en=0 immediately, in-flight writes discarded); done not pulsed. Abort together with start in IDLE has no effect on start; start is accepted.
- Counters wrap only under FSM control; k never exceeds N/2-1 and stage never exceeds LOG2N-1.

Test Plan:
- LOG2N=3, defaults (WR_DLY=5), pulse start -> stage0 pairs (0,1)(2,3)(4,5)(6,7) with tw 0,0,0,0; stage1 (0,2)(1,3)(4,6)(5,7) with tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3.
- Same run -> busy high exactly 27 cycles, done one cycle immediately after; each wr_en/wr_addr pair equals the rd pair 5 cycles earlier; no rd_en within 5 cycles after any stage's last issue.
- Pulse start again while busy (cycle 10) -> sequence and done timing identical to the previous test; no second frame.
- abort in cycle 12 -> next cycle busy=0, rd_en=0, wr_en=0, stage=0; done never pulses; a new start then yields the full 27-cycle frame.
- rst_n low mid-stage 1 -> all outputs 0 asynchronously; no wr_en after release; IDLE until start.
- LOG2N=6 -> first stage-5 issue gives addresses (0,32) with tw 0; last issue gives (31,63) with tw 31; done after 6*(32+5)=222 busy cycles.
